// File: rtl/kf6845_pkg.sv
// Shared KF6845 CRTC definitions: register indices, R3 field layout and
// the character counter step used by both timing stages.
package kf6845_pkg;

    localparam int HSYNC_WIDTH_MSB = 3;
    localparam int VSYNC_WIDTH_LSB = 4;

    localparam logic [4:0] R0  = 5'd0;
    localparam logic [4:0] R1  = 5'd1;
    localparam logic [4:0] R2  = 5'd2;
    localparam logic [4:0] R3  = 5'd3;
    localparam logic [4:0] R4  = 5'd4;
    localparam logic [4:0] R5  = 5'd5;
    localparam logic [4:0] R6  = 5'd6;
    localparam logic [4:0] R7  = 5'd7;
    localparam logic [4:0] R8  = 5'd8;
    localparam logic [4:0] R9  = 5'd9;
    localparam logic [4:0] R10 = 5'd10;
    localparam logic [4:0] R11 = 5'd11;
    localparam logic [4:0] R12 = 5'd12;
    localparam logic [4:0] R13 = 5'd13;
    localparam logic [4:0] R14 = 5'd14;
    localparam logic [4:0] R15 = 5'd15;
    localparam logic [4:0] R16 = 5'd16;
    localparam logic [4:0] R17 = 5'd17;

    typedef logic [7:0] char_count_t;

    // Only an exact match ends the line; a counter above the total wraps through 255.
    function automatic char_count_t next_character(input char_count_t current,
                                                   input char_count_t total);
        char_count_t result;
        if (current == total) begin
            result = 8'd0;
        end else begin
            result = current + 8'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/kf6845_sync_pulse_generator.sv
// Retriggerable sync pulse of 1..16 ticks (width code 0 means 16).
// Shared by the horizontal and vertical stages.
module kf6845_sync_pulse_generator (
    input  logic       clock,
    input  logic       reset,
    input  logic       tick,
    input  logic       trigger,
    input  logic [3:0] width,
    output logic       pulse,
    output logic [3:0] remaining
);

    logic       pulse_r;
    logic [3:0] remaining_r;
    logic       pulse_next_s;
    logic [3:0] remaining_next_s;

    // Next pulse state; width-1 wraps 0 to 15, giving the 16-tick case.
    always_comb begin
        pulse_next_s     = pulse_r;
        remaining_next_s = remaining_r;
        if (tick) begin
            if (trigger) begin
                pulse_next_s     = 1'b1;
                remaining_next_s = width - 4'd1;
            end else if (pulse_r) begin
                if (remaining_r == 4'd0) begin
                    pulse_next_s = 1'b0;
                end else begin
                    remaining_next_s = remaining_r - 4'd1;
                end
            end else begin
                pulse_next_s = 1'b0;
            end
        end else begin
            pulse_next_s = pulse_r;
        end
    end

    // Pulse state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pulse_r     <= 1'b0;
            remaining_r <= 4'd0;
        end else begin
            pulse_r     <= pulse_next_s;
            remaining_r <= remaining_next_s;
        end
    end

    assign pulse     = pulse_r;
    assign remaining = remaining_r;

endmodule

// File: rtl/kf6845_horizontal_control.sv
// KF6845 horizontal timing: R0-R3 storage, character counter, display
// enable, HSYNC and the end-of-line tick for the vertical stage.
module kf6845_horizontal_control
    import kf6845_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       character_clock_enable,
    input  logic [7:0] internal_data_bus,
    input  logic       write_horizontal_total_register,
    input  logic       write_horizontal_displayed_register,
    input  logic       write_horizontal_sync_position_register,
    input  logic       write_horizontal_sync_width_register,
    output logic [7:0] horizontal_counter,
    output logic       horizontal_display,
    output logic       hsync,
    output logic       end_of_line,
    output logic [3:0] vertical_sync_width
);

    logic [7:0]  r0_r;
    logic [7:0]  r1_r;
    logic [7:0]  r2_r;
    logic [7:0]  r3_r;
    char_count_t counter_r;
    logic        display_r;
    char_count_t next_count_s;
    logic        sync_trigger_s;
    logic [3:0]  hsync_remaining_unused_s;

    // Register file; writes ignore the character tick.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r0_r <= 8'd0;
            r1_r <= 8'd0;
            r2_r <= 8'd0;
            r3_r <= 8'd0;
        end else begin
            if (write_horizontal_total_register)         r0_r <= internal_data_bus;
            if (write_horizontal_displayed_register)     r1_r <= internal_data_bus;
            if (write_horizontal_sync_position_register) r2_r <= internal_data_bus;
            if (write_horizontal_sync_width_register)    r3_r <= internal_data_bus;
        end
    end

    // Display and sync are decided for the character about to be shown.
    always_comb begin
        next_count_s   = next_character(counter_r, r0_r);
        sync_trigger_s = (next_count_s == r2_r);
    end

    // Character counter and display enable, advanced only on ticks.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            counter_r <= 8'd0;
            display_r <= 1'b0;
        end else if (character_clock_enable) begin
            counter_r <= next_count_s;
            display_r <= (next_count_s < r1_r);
        end
    end

    kf6845_sync_pulse_generator u_hsync (
        .clock     (clock),
        .reset     (reset),
        .tick      (character_clock_enable),
        .trigger   (sync_trigger_s),
        .width     (r3_r[HSYNC_WIDTH_MSB:0]),
        .pulse     (hsync),
        .remaining (hsync_remaining_unused_s)
    );

    assign horizontal_counter  = counter_r;
    assign horizontal_display  = display_r;
    assign end_of_line         = character_clock_enable && (counter_r == r0_r);
    assign vertical_sync_width = r3_r[7:VSYNC_WIDTH_LSB];

endmodule

// File: tb/tb_kf6845_horizontal_control.sv
// Self-checking bench: directed line scenarios plus random writes/ticks,
// compared every cycle against a behavioural model of the horizontal timing.
module tb_kf6845_horizontal_control;

    logic       clock = 1'b0;
    logic       reset;
    logic       character_clock_enable;
    logic [7:0] internal_data_bus;
    logic       w0, w1, w2, w3;
    logic [7:0] horizontal_counter;
    logic       horizontal_display;
    logic       hsync;
    logic       end_of_line;
    logic [3:0] vertical_sync_width;

    kf6845_horizontal_control dut (
        .clock                                   (clock),
        .reset                                   (reset),
        .character_clock_enable                  (character_clock_enable),
        .internal_data_bus                       (internal_data_bus),
        .write_horizontal_total_register         (w0),
        .write_horizontal_displayed_register     (w1),
        .write_horizontal_sync_position_register (w2),
        .write_horizontal_sync_width_register    (w3),
        .horizontal_counter                      (horizontal_counter),
        .horizontal_display                      (horizontal_display),
        .hsync                                   (hsync),
        .end_of_line                             (end_of_line),
        .vertical_sync_width                     (vertical_sync_width)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Model: counter position, display flag, characters left in the sync pulse.
    int         m_cnt;
    int         m_disp;
    int         m_left;
    logic [7:0] m_r [4];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_cnt = 0; m_disp = 0; m_left = 0;
        for (int i = 0; i < 4; i++) m_r[i] = 8'd0;
    endtask

    task automatic model_step();
        int nxt;
        int w;
        if (reset) begin
            model_clear();
        end else begin
            if (character_clock_enable) begin
                nxt = (m_cnt == int'(m_r[0])) ? 0 : (m_cnt + 1) % 256;
                m_disp = (nxt < int'(m_r[1])) ? 1 : 0;
                w = int'(m_r[3] % 16);
                if (nxt == int'(m_r[2])) m_left = (w == 0) ? 16 : w;
                else if (m_left > 0)     m_left = m_left - 1;
                m_cnt = nxt;
            end
            if (w0) m_r[0] = internal_data_bus;
            if (w1) m_r[1] = internal_data_bus;
            if (w2) m_r[2] = internal_data_bus;
            if (w3) m_r[3] = internal_data_bus;
        end
    endtask

    task automatic cycle();
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic write_reg(input int idx, input logic [7:0] data);
        internal_data_bus = data;
        case (idx)
            0: w0 = 1'b1;
            1: w1 = 1'b1;
            2: w2 = 1'b1;
            default: w3 = 1'b1;
        endcase
        cycle();
        w0 = 1'b0; w1 = 1'b0; w2 = 1'b0; w3 = 1'b0;
    endtask

    task automatic wait_count(input int target, input int limit);
        int n = 0;
        while (m_cnt != target && n < limit) begin
            cycle();
            n++;
        end
        check("wait_counter", int'(horizontal_counter), target);
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clock) begin
        check("counter", int'(horizontal_counter), m_cnt);
        check("display", int'(horizontal_display), m_disp);
        check("hsync", int'(hsync), (m_left > 0) ? 1 : 0);
        check("end_of_line", int'(end_of_line),
              (character_clock_enable && m_cnt == int'(m_r[0])) ? 1 : 0);
        check("vsync_width", int'(vertical_sync_width), int'(m_r[3] / 16));
    end

    initial begin
        int c;
        int highs;
        int n;
        reset = 1'b1;
        character_clock_enable = 1'b0;
        internal_data_bus = 8'd0;
        w0 = 1'b0; w1 = 1'b0; w2 = 1'b0; w3 = 1'b0;
        model_clear();
        repeat (2) cycle();

        // Reset state, literal expectations.
        character_clock_enable = 1'b1;
        #1;
        check("rst_counter", int'(horizontal_counter), 0);
        check("rst_display", int'(horizontal_display), 0);
        check("rst_hsync", int'(hsync), 0);
        check("rst_vsw", int'(vertical_sync_width), 0);
        check("rst_eol", int'(end_of_line), 1);
        character_clock_enable = 1'b0;
        reset = 1'b0;

        // Basic line: counter 0..9, display 0-5, hsync 7-8, eol at 9.
        write_reg(0, 8'd9);
        write_reg(1, 8'd6);
        write_reg(2, 8'd7);
        write_reg(3, 8'h32);
        character_clock_enable = 1'b1;
        repeat (12) cycle();
        for (int k = 0; k < 20; k++) begin
            cycle();
            c = (2 + k + 1) % 10;
            check("basic_counter", int'(horizontal_counter), c);
            check("basic_display", int'(horizontal_display), (c < 6) ? 1 : 0);
            check("basic_hsync", int'(hsync), (c == 7 || c == 8) ? 1 : 0);
            check("basic_eol", int'(end_of_line), (c == 9) ? 1 : 0);
            check("basic_vsw", int'(vertical_sync_width), 3);
        end

        // Sync pulse crossing the line wrap: high at 8, 9, 0, 1.
        character_clock_enable = 1'b0;
        write_reg(2, 8'd8);
        write_reg(3, 8'h04);
        character_clock_enable = 1'b1;
        repeat (20) cycle();
        for (int k = 0; k < 20; k++) begin
            cycle();
            c = (2 + k + 1) % 10;
            check("wrap_hsync", int'(hsync), (c >= 8 || c <= 1) ? 1 : 0);
        end

        // Width code 0 gives 16 characters, counter 4..19.
        character_clock_enable = 1'b0;
        write_reg(0, 8'd31);
        write_reg(2, 8'd4);
        write_reg(3, 8'h00);
        character_clock_enable = 1'b1;
        repeat (32) cycle();
        highs = 0;
        for (int k = 0; k < 32; k++) begin
            cycle();
            c = (2 + k + 1) % 32;
            check("w16_hsync", int'(hsync), (c >= 4 && c <= 19) ? 1 : 0);
            if (hsync) highs++;
        end
        check("w16_length", highs, 16);

        // Tick on every third clock.
        for (int k = 0; k < 60; k++) begin
            character_clock_enable = (k % 3 == 0);
            cycle();
        end

        // R0 shrink below the running counter: overrun through 255.
        character_clock_enable = 1'b0;
        write_reg(0, 8'd20);
        character_clock_enable = 1'b1;
        wait_count(15, 300);
        internal_data_bus = 8'd9;
        w0 = 1'b1;
        cycle();
        w0 = 1'b0;
        n = 0;
        while (n < 300) begin
            cycle();
            n++;
            if (end_of_line) break;
        end
        check("shrink_ticks", n, 249);
        check("shrink_counter", int'(horizontal_counter), 9);

        // Random writes, ticks and occasional resets.
        for (int k = 0; k < 3000; k++) begin
            character_clock_enable = ($urandom_range(0, 3) != 0);
            internal_data_bus = 8'($urandom_range(0, 255));
            w0 = ($urandom_range(0, 63) == 0);
            w1 = ($urandom_range(0, 31) == 0);
            w2 = ($urandom_range(0, 31) == 0);
            w3 = ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 299) == 0) begin
                reset = 1'b1;
                model_clear();
            end else begin
                reset = 1'b0;
            end
            cycle();
        end
        reset = 1'b0;
        w0 = 1'b0; w1 = 1'b0; w2 = 1'b0; w3 = 1'b0;

        // Reset mid-line while hsync is active.
        character_clock_enable = 1'b0;
        write_reg(0, 8'd9);
        write_reg(1, 8'd6);
        write_reg(2, 8'd3);
        write_reg(3, 8'h54);
        character_clock_enable = 1'b1;
        wait_count(3, 300);
        repeat (2) cycle();
        check("mid_counter", int'(horizontal_counter), 5);
        check("mid_hsync", int'(hsync), 1);
        #2;
        reset = 1'b1;
        model_clear();
        #1;
        check("async_counter", int'(horizontal_counter), 0);
        check("async_display", int'(horizontal_display), 0);
        check("async_hsync", int'(hsync), 0);
        check("async_vsw", int'(vertical_sync_width), 0);
        repeat (2) cycle();
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            cycle();
            check("post_rst_counter", int'(horizontal_counter), 0);
            check("post_rst_eol", int'(end_of_line), 1);
        end

        character_clock_enable = 1'b0;
        @(negedge clock);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
